// File: rtl/delay_line_sequencer_pkg.sv
// rtl/delay_line_sequencer_pkg.sv - shared types and constants for the delay line sequencer
package delay_line_sequencer_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_ECHO   = 2'd1,
        MODE_PLAY   = 2'd2
    } mode_t;

endpackage

// File: rtl/delay_line_sequencer_if.sv
// rtl/delay_line_sequencer_if.sv - single-port off-chip memory bus with ready handshake
interface delay_line_sequencer_if #(
    parameter int ADDR_W = delay_line_sequencer_pkg::ADDR_W_DEF,
    parameter int DATA_W = delay_line_sequencer_pkg::DATA_W_DEF
);
    logic              memory_we;
    logic              memory_re;
    logic [ADDR_W-1:0] address_out;
    logic [DATA_W-1:0] data_out;
    logic              off_chip_mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output memory_we, memory_re, address_out, data_out,
        input  off_chip_mem_ready, mem_rdata
    );

    modport slave (
        input  memory_we, memory_re, address_out, data_out,
        output off_chip_mem_ready, mem_rdata
    );
endinterface

// File: rtl/delay_line_sequencer_tick_sync.sv
// rtl/delay_line_sequencer_tick_sync.sv - 2-FF synchronizer plus rising-edge pulse for ADC-domain clocks
module delay_line_sequencer_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_pulse;

    // Pulse is registered so it lands exactly three clk edges after the async rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_pulse <= r_sync2 & ~r_sync3;
        end
    end

    assign o_pulse = r_pulse;
endmodule

// File: rtl/delay_line_sequencer.sv
// rtl/delay_line_sequencer.sv - per-ADC-sample echo/loop memory sequencer feeding the output mixer
module delay_line_sequencer
    import delay_line_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_adc_clock,
    input  logic [DATA_W-1:0]    i_sample_in,
    input  logic                 i_record,
    input  logic                 i_loop,
    input  logic [ADDR_W-1:0]    i_delay_reverb,
    delay_line_sequencer_if.master mem,
    output logic [DATA_W-1:0]    o_sample_out,
    output logic                 o_sample_valid,
    output logic                 o_busy,
    output logic                 o_overrun
);
    localparam logic [DATA_W-1:0] L_SAT_MAX =
        (DATA_W == 16) ? DATA_W'(SAT_MAX) : {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] L_SAT_MIN =
        (DATA_W == 16) ? DATA_W'(SAT_MIN) : {1'b1, {(DATA_W-1){1'b0}}};

    state_t r_state;
    state_t w_next;
    mode_t  r_mode;
    mode_t  w_tick_mode;

    logic              w_tick;
    logic              w_ready;
    logic [DATA_W-1:0] w_rdata;

    logic [DATA_W-1:0] r_s_lat;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_sample_hold;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_data_hold;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_play_ptr;
    logic [ADDR_W-1:0] r_loop_len;
    logic              r_record_d;
    logic              r_overrun;

    logic              w_we;
    logic              w_re;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_echo_mix;
    logic [DATA_W-1:0] w_result;
    logic [ADDR_W-1:0] w_play_inc;

    delay_line_sequencer_tick_sync u_tick_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_adc_clock),
        .o_pulse (w_tick)
    );

    assign w_ready = mem.off_chip_mem_ready;
    assign w_rdata = mem.mem_rdata;

    // An empty loop has nothing to play, so it degrades to a straight pass-through.
    always_comb begin
        w_tick_mode = MODE_BYPASS;
        if (i_record) begin
            w_tick_mode = MODE_ECHO;
        end else if (i_loop && (r_loop_len != '0)) begin
            w_tick_mode = MODE_PLAY;
        end
    end

    assign w_rd_addr  = (r_mode == MODE_ECHO) ? (r_wr_ptr - i_delay_reverb) : r_play_ptr;
    assign w_sum      = {r_s_lat[DATA_W-1], r_s_lat} + {r_rd_data[DATA_W-1], r_rd_data};
    assign w_echo_mix = (w_sum[DATA_W] != w_sum[DATA_W-1])
                        ? (w_sum[DATA_W] ? L_SAT_MIN : L_SAT_MAX)
                        : w_sum[DATA_W-1:0];
    assign w_result   = (r_mode == MODE_ECHO) ? w_echo_mix : r_rd_data;
    assign w_play_inc = r_play_ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    case (w_tick_mode)
                        MODE_ECHO: w_next = ST_WRITE;
                        MODE_PLAY: w_next = ST_READ;
                        default:   w_next = ST_DONE;
                    endcase
                end
            end
            ST_WRITE: if (w_ready) w_next = ST_READ;
            ST_READ:  if (w_ready) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_we           = 1'b0;
        w_re           = 1'b0;
        w_addr         = r_addr_hold;
        w_data         = r_data_hold;
        o_sample_valid = 1'b0;
        o_sample_out   = r_sample_hold;
        o_busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_WRITE: begin
                w_we   = 1'b1;
                w_addr = r_wr_ptr;
                w_data = r_s_lat;
            end
            ST_READ: begin
                w_re   = 1'b1;
                w_addr = w_rd_addr;
            end
            ST_DONE: begin
                o_sample_valid = 1'b1;
                o_sample_out   = w_result;
            end
            default: ;
        endcase
    end

    assign mem.memory_we   = w_we;
    assign mem.memory_re   = w_re;
    assign mem.address_out = w_addr;
    assign mem.data_out    = w_data;
    assign o_overrun       = r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_lat       <= '0;
            r_rd_data     <= '0;
            r_sample_hold <= '0;
            r_addr_hold   <= '0;
            r_data_hold   <= '0;
            r_wr_ptr      <= '0;
            r_play_ptr    <= '0;
            r_loop_len    <= '0;
            r_record_d    <= 1'b0;
            r_overrun     <= 1'b0;
            r_mode        <= MODE_BYPASS;
        end else begin
            r_record_d  <= i_record;
            r_addr_hold <= w_addr;
            r_data_hold <= w_data;

            // Ticks are only accepted in IDLE; anything else is lost and flagged.
            if (w_tick) begin
                if (r_state == ST_IDLE) begin
                    r_s_lat <= i_sample_in;
                    r_mode  <= w_tick_mode;
                    if (w_tick_mode == MODE_BYPASS) begin
                        r_rd_data <= i_sample_in;
                    end
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            if ((r_state == ST_READ) && w_ready) begin
                r_rd_data <= w_rdata;
            end

            if (r_state == ST_DONE) begin
                r_sample_hold <= w_result;
                if (r_mode == MODE_ECHO) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end else if (r_mode == MODE_PLAY) begin
                    r_play_ptr <= (w_play_inc == r_loop_len) ? '0 : w_play_inc;
                end
            end

            // Record edges override the pointer stepping above.
            if (i_record && !r_record_d) begin
                r_wr_ptr <= '0;
            end
            if (!i_record && r_record_d) begin
                r_loop_len <= r_wr_ptr;
                r_play_ptr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_delay_line_sequencer.sv
// tb/tb_delay_line_sequencer.sv - directed self-checking bench with a behavioural echo/loop model
module tb_delay_line_sequencer;
    logic        clk;
    logic        rst;
    logic        adc_clock;
    logic [15:0] sample_in;
    logic        record;
    logic        loop;
    logic [15:0] delay_reverb;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun;
    logic        ready_en;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_mem_act = 0;

    delay_line_sequencer_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

    delay_line_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_adc_clock    (adc_clock),
        .i_sample_in    (sample_in),
        .i_record       (record),
        .i_loop         (loop),
        .i_delay_reverb (delay_reverb),
        .mem            (mem_if),
        .o_sample_out   (sample_out),
        .o_sample_valid (sample_valid),
        .o_busy         (busy),
        .o_overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem_arr [0:65535];
    assign mem_if.off_chip_mem_ready = ready_en;
    assign mem_if.mem_rdata          = mem_arr[mem_if.address_out];
    always @(posedge clk) begin
        if (mem_if.memory_we && mem_if.off_chip_mem_ready)
            mem_arr[mem_if.address_out] <= mem_if.data_out;
    end

    // Behavioural model: sparse memory image plus the three pointers.
    logic [15:0] m_mem [int];
    logic [15:0] m_wr, m_play, m_len;
    logic [15:0] exp_out[$], exp_waddr[$], exp_wdata[$], exp_raddr[$];
    logic [15:0] obs_out[$], obs_waddr[$], obs_raddr[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input logic [15:0] q[$], input int idx);
        if (idx < q.size()) return {16'h0, q[idx]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        if (m_mem.exists(int'(a))) return m_mem[int'(a)];
        return 16'h0;
    endfunction

    function automatic logic [15:0] m_sat(input int v);
        int c;
        c = v;
        if (c > 32767) return 16'h7FFF;
        if (c < -32768) return 16'h8000;
        return c[15:0];
    endfunction

    task automatic model_tick(input logic [15:0] s);
        logic [15:0] ra;
        int a, b;
        if (record) begin
            exp_waddr.push_back(m_wr);
            exp_wdata.push_back(s);
            m_mem[int'(m_wr)] = s;
            ra = m_wr - delay_reverb;
            exp_raddr.push_back(ra);
            a = $signed(s);
            b = $signed(m_rd(ra));
            exp_out.push_back(m_sat(a + b));
            m_wr = m_wr + 16'd1;
        end else if (loop && m_len != 16'd0) begin
            exp_raddr.push_back(m_play);
            exp_out.push_back(m_rd(m_play));
            if (int'(m_play) + 1 == int'(m_len)) m_play = 16'd0;
            else m_play = m_play + 16'd1;
        end else begin
            exp_out.push_back(s);
        end
    endtask

    task automatic set_record(input logic v);
        @(negedge clk);
        if (v && !record) m_wr = 16'd0;
        if (!v && record) begin
            m_len  = m_wr;
            m_play = 16'd0;
        end
        record = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic adc_tick(input logic [15:0] s, output int lat, output int nv);
        lat = -1;
        nv  = 0;
        @(negedge clk);
        sample_in = s;
        adc_clock = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                nv++;
                if (lat < 0) lat = i;
            end
            if (i == 10) adc_clock = 1'b0;
        end
    endtask

    task automatic do_tick(input string name, input logic [15:0] s, input int exp_lat);
        int lat, nv;
        model_tick(s);
        adc_tick(s, lat, nv);
        check({name, "_nvalid"}, nv, 1);
        if (exp_lat >= 0) check({name, "_latency"}, lat, exp_lat);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sample_valid) begin
                n_valid++;
                obs_out.push_back(sample_out);
                if (exp_out.size() > 0) check("sample_out", sample_out, exp_out.pop_front());
                else check("unexpected_valid", 1, 0);
            end
            if (mem_if.memory_we || mem_if.memory_re) begin
                n_mem_act++;
                check("we_re_exclusive", mem_if.memory_we & mem_if.memory_re, 0);
            end
            if (mem_if.memory_we && ready_en) begin
                obs_waddr.push_back(mem_if.address_out);
                if (exp_waddr.size() > 0) begin
                    check("write_addr", mem_if.address_out, exp_waddr.pop_front());
                    check("write_data", mem_if.data_out, exp_wdata.pop_front());
                end else check("unexpected_write", 1, 0);
            end
            if (mem_if.memory_re && ready_en) begin
                obs_raddr.push_back(mem_if.address_out);
                if (exp_raddr.size() > 0) check("read_addr", mem_if.address_out, exp_raddr.pop_front());
                else check("unexpected_read", 1, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bo, br, bw, v0, a0;
        for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0;
        m_wr = 0; m_play = 0; m_len = 0;
        rst = 1'b1; adc_clock = 1'b0; sample_in = 16'h0; record = 1'b0;
        loop = 1'b0; delay_reverb = 16'h0; ready_en = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_sample_out", sample_out, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_we_re", {mem_if.memory_we, mem_if.memory_re}, 0);
        check("rst_addr", mem_if.address_out, 0);
        check("rst_data", mem_if.data_out, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Bypass: no memory traffic, sample passes straight through.
        bo = obs_out.size();
        a0 = n_mem_act;
        do_tick("bypass", 16'h1234, 4);
        check("bypass_out", q_at(obs_out, bo), 16'h1234);
        check("bypass_no_mem", n_mem_act, a0);

        // Reset while a write is stalled on ready.
        set_record(1'b1);
        ready_en = 1'b0;
        @(negedge clk);
        sample_in = 16'h5555;
        adc_clock = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_if.memory_we) break;
        end
        check("stall_we_high", mem_if.memory_we, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_we", mem_if.memory_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", mem_if.address_out, 0);
        check("midrst_data", mem_if.data_out, 0);
        check("midrst_out", sample_out, 0);
        adc_clock = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ready_en = 1'b1;
        m_wr = 0; m_play = 0; m_len = 0;
        repeat (3) @(negedge clk);
        check("postrst_busy", busy, 0);

        // Echo with a two-sample tap starting at address 0.
        delay_reverb = 16'd2;
        bo = obs_out.size(); br = obs_raddr.size(); bw = obs_waddr.size();
        do_tick("echo0", 16'h0100, 6);
        do_tick("echo1", 16'h0200, -1);
        do_tick("echo2", 16'h0300, -1);
        check("echo_out0", q_at(obs_out, bo),     16'h0100);
        check("echo_out1", q_at(obs_out, bo + 1), 16'h0200);
        check("echo_out2", q_at(obs_out, bo + 2), 16'h0400);
        check("echo_raddr0", q_at(obs_raddr, br),     16'hFFFE);
        check("echo_raddr1", q_at(obs_raddr, br + 1), 16'hFFFF);
        check("echo_raddr2", q_at(obs_raddr, br + 2), 16'h0000);
        check("echo_waddr2", q_at(obs_waddr, bw + 2), 16'h0002);

        // Zero tap reads back the just-written sample and saturates both ways.
        delay_reverb = 16'd0;
        bo = obs_out.size();
        do_tick("sat_pos", 16'h6000, -1);
        do_tick("sat_neg", 16'h9000, -1);
        check("sat_pos_out", q_at(obs_out, bo),     16'h7FFF);
        check("sat_neg_out", q_at(obs_out, bo + 1), 16'h8000);

        // Record a three-sample loop and play it back with wrap.
        set_record(1'b0);
        set_record(1'b1);
        do_tick("rec0", 16'h0011, -1);
        do_tick("rec1", 16'h0022, -1);
        do_tick("rec2", 16'h0033, -1);
        set_record(1'b0);
        check("loop_len_model", m_len, 3);
        loop = 1'b1;
        bo = obs_out.size(); br = obs_raddr.size();
        do_tick("play0", 16'h7777, 5);
        for (int k = 1; k < 7; k++) do_tick("play", 16'h7777, -1);
        for (int k = 0; k < 7; k++) begin
            logic [15:0] lit_out [0:2];
            lit_out[0] = 16'h0011; lit_out[1] = 16'h0022; lit_out[2] = 16'h0033;
            check("loop_out", q_at(obs_out, bo + k), lit_out[k % 3]);
            check("loop_raddr", q_at(obs_raddr, br + k), k % 3);
        end

        // Second tick lands while the read is stalled and must be dropped.
        check("pre_overrun", overrun, 0);
        ready_en = 1'b0;
        v0 = n_valid;
        bo = obs_out.size();
        model_tick(16'h0BAD);
        sample_in = 16'h0BAD;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            adc_clock = (i < 40) && ((i % 20) < 10);
            if (i == 40) ready_en = 1'b1;
        end
        check("overrun_flag", overrun, 1);
        check("overrun_one_valid", n_valid - v0, 1);
        check("overrun_out", q_at(obs_out, bo), 16'h0022);

        check("exp_out_drained", exp_out.size(), 0);
        check("exp_raddr_drained", exp_raddr.size(), 0);
        check("exp_waddr_drained", exp_waddr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
